// File: rtl/spi_master_engine.sv
// SPI master transfer engine: one word per start pulse, run-time CPOL/CPHA,
// programmable SCLK rate, multiple chip selects and a start/busy/done/err handshake.
module spi_master_engine #(
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_CS      = 3,
    parameter int CS_WIDTH    = 2,
    parameter int HALF_PERIOD = 4,
    parameter int MSB_FIRST   = 1
) (
    input  logic                  I_CLK,
    input  logic                  I_RESETN,
    input  logic                  start,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic [CS_WIDTH-1:0]   cs_sel,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  SCLK_MASTER,
    output logic                  MOSI_MASTER,
    input  logic                  MISO_MASTER,
    output logic [NUM_CS-1:0]     SS_N_MASTER
);

    localparam int HP_W = $clog2(HALF_PERIOD);
    localparam int BC_W = $clog2(2 * DATA_WIDTH);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;

    logic [2:0]            state;
    logic [HP_W-1:0]       hp_cnt;
    logic [BC_W-1:0]       bit_cnt;
    logic                  cpol_q, cpha_q, sclk_q, mosi_q;
    logic [CS_WIDTH-1:0]   cs_q;
    logic [DATA_WIDTH-1:0] tx_sh, rx_sh, rx_q;

    function automatic logic first_bit(input logic [DATA_WIDTH-1:0] d);
        return (MSB_FIRST != 0) ? d[DATA_WIDTH-1] : d[0];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] d);
        return (MSB_FIRST != 0) ? {d[DATA_WIDTH-2:0], 1'b0} : {1'b0, d[DATA_WIDTH-1:1]};
    endfunction

    function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] d,
                                                       input logic b);
        return (MSB_FIRST != 0) ? {d[DATA_WIDTH-2:0], b} : {b, d[DATA_WIDTH-1:1]};
    endfunction

    logic hp_last, sclk_edge, leading, last_edge, sample, advance, active, cs_bad;

    assign hp_last   = (hp_cnt == HP_W'(HALF_PERIOD - 1));
    assign sclk_edge = (state == S_SHIFT) && hp_last;
    // Even-numbered edges leave the idle level (leading), odd ones return to it.
    assign leading   = ~bit_cnt[0];
    assign last_edge = (bit_cnt == BC_W'(2 * DATA_WIDTH - 1));
    assign sample    = sclk_edge && (cpha_q ? ~leading : leading);
    assign advance   = sclk_edge && (cpha_q ? leading : (~leading && ~last_edge));
    assign active    = (state == S_SETUP) || (state == S_SHIFT) || (state == S_HOLD);
    assign cs_bad    = ({1'b0, cs_sel} >= (CS_WIDTH + 1)'(NUM_CS));

    always_ff @(posedge I_CLK or negedge I_RESETN) begin
        if (!I_RESETN) begin
            state   <= S_IDLE;
            hp_cnt  <= '0;
            bit_cnt <= '0;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            cs_q    <= '0;
            tx_sh   <= '0;
            rx_sh   <= '0;
            rx_q    <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    cpol_q  <= cpol;
                    cpha_q  <= cpha;
                    cs_q    <= cs_sel;
                    sclk_q  <= cpol;
                    hp_cnt  <= '0;
                    bit_cnt <= '0;
                    // CPHA=0 presents bit 0 during setup; CPHA=1 drives it on the first leading edge.
                    mosi_q  <= cpha ? 1'b0 : first_bit(tx_data);
                    tx_sh   <= cpha ? tx_data : shift_out(tx_data);
                    state   <= cs_bad ? S_ERR : S_SETUP;
                end
                S_SETUP: begin
                    hp_cnt <= hp_last ? '0 : hp_cnt + HP_W'(1);
                    if (hp_last) state <= S_SHIFT;
                end
                S_SHIFT: begin
                    hp_cnt <= hp_last ? '0 : hp_cnt + HP_W'(1);
                    if (hp_last) begin
                        sclk_q  <= ~sclk_q;
                        bit_cnt <= bit_cnt + BC_W'(1);
                        if (last_edge) state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    hp_cnt <= hp_last ? '0 : hp_cnt + HP_W'(1);
                    if (hp_last) begin
                        rx_q  <= rx_sh;
                        state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
            if (sample) rx_sh <= shift_in(rx_sh, MISO_MASTER);
            if (advance) begin
                mosi_q <= first_bit(tx_sh);
                tx_sh  <= shift_out(tx_sh);
            end
        end
    end

    always_comb begin
        SS_N_MASTER = '1;
        if (active) begin
            for (int i = 0; i < NUM_CS; i++)
                if (cs_q == CS_WIDTH'(i)) SS_N_MASTER[i] = 1'b0;
        end
    end

    assign SCLK_MASTER = sclk_q;
    assign MOSI_MASTER = active & mosi_q;
    assign rx_data     = rx_q;
    assign busy        = active || (state == S_ERR);
    assign done        = (state == S_DONE) || (state == S_ERR);
    assign err         = (state == S_ERR);

endmodule

// File: doc/spi_master_engine.md
Name: spi_master_engine

Overview:
- Parametrised, self-contained SPI master transfer engine. Next generation of the board-level SPI master path.
- Replaces the fixed 8-bit, single-slave, mode-0 arrangement with:
  - configurable word width;
  - multiple chip selects;
  - run-time CPOL/CPHA;
  - programmable SCLK rate;
  - bit order selection;
  - an explicit start/busy/done/error handshake.
- Sits between the control FSM (which issues start pulses and consumes received words) and the board SPI pins.

Parameters:
- DATA_WIDTH, 8: bits per transfer; legal range 2..32.
- NUM_CS, 3: number of slave-select lines.
- CS_WIDTH, 2: width of cs_sel; must satisfy 2**CS_WIDTH >= NUM_CS.
- HALF_PERIOD, 4: I_CLK cycles per SCLK half-period; minimum 2.
- MSB_FIRST, 1: 1 = MSB shifted first on both MOSI and MISO; 0 = LSB first.

Ports:
- I_CLK  input  1  system clock; all logic on its rising edge.
- I_RESETN  input  1  asynchronous active-low reset.
- start  input  1  single-cycle transfer request.
- cpol  input  1  clock polarity; sampled when a start is accepted.
- cpha  input  1  clock phase; sampled when a start is accepted.
- cs_sel  input  CS_WIDTH  slave index; sampled when a start is accepted.
- tx_data  input  DATA_WIDTH  word to send; sampled when a start is accepted.
- rx_data  output  DATA_WIDTH  last received word.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle completion pulse.
- err  output  1  high with done when cs_sel was invalid.
- SCLK_MASTER  output  1  SPI clock.
- MOSI_MASTER  output  1  master data out.
- MISO_MASTER  input  1  master data in.
- SS_N_MASTER  output  NUM_CS  active-low selects, one-hot-low when active.

Behaviour:
- Reset (asynchronous, I_RESETN=0), effective immediately, including mid-transfer:
  - state = IDLE; busy=0, done=0, err=0, rx_data=0, MOSI_MASTER=0;
  - SS_N_MASTER all ones; latched cpol=0, so SCLK_MASTER=0; shift registers cleared.
- States:
  - IDLE
  - SETUP: SS asserted, SCLK idle, HALF_PERIOD cycles.
  - SHIFT: 2*DATA_WIDTH half-periods.
  - HOLD: SCLK idle, SS still asserted, HALF_PERIOD cycles.
  - DONE: 1 cycle; SS deasserted, done=1.
  - ERR: 1 cycle; done=1, err=1, SS stays deasserted.
- Start acceptance: start is accepted only in IDLE. A start in any other state is ignored and has no side effects.
- On acceptance:
  - latch cpol, cpha, cs_sel and tx_data;
  - if cs_sel >= NUM_CS, go to ERR; otherwise go to SETUP.
- SS timing: SS_N_MASTER[cs_sel] goes low in the first SETUP cycle, i.e. the cycle after start.
- SCLK level:
  - SCLK_MASTER equals the latched cpol in IDLE, SETUP, HOLD, DONE and ERR.
  - In SHIFT it toggles every HALF_PERIOD cycles, giving exactly DATA_WIDTH leading and DATA_WIDTH trailing edges.
- CPHA=0:
  - the first data bit is on MOSI from the first SETUP cycle;
  - MISO is sampled on every leading edge;
  - MOSI advances on every trailing edge except the last.
- CPHA=1:
  - MOSI is driven with the first bit at the first leading edge;
  - MOSI advances on each subsequent leading edge;
  - MISO is sampled on every trailing edge.
- Bit order: set by MSB_FIRST and applied identically to transmit and receive.
- MOSI outside SETUP/SHIFT/HOLD: driven 0.
- Latency, valid transfer: done is high exactly 1 + (2*DATA_WIDTH+2)*HALF_PERIOD cycles after the start cycle (73 cycles with defaults). rx_data updates in that same cycle.
- Latency, invalid cs_sel: done=1 and err=1 in the cycle after start; rx_data is unchanged.
- rx_data hold: held until the next successful transfer completes.
- busy: high in SETUP, SHIFT, HOLD and ERR; low in DONE and IDLE.
- Back-to-back transfers: a start asserted during the done cycle is ignored. The next start is accepted from the first cycle after done.
- Counter: the half-period counter is ceil(log2(HALF_PERIOD)) bits wide and wraps to 0 at HALF_PERIOD-1. The bit counter counts edges 0..2*DATA_WIDTH-1.
- Sampled inputs: changes to cpol, cpha, cs_sel or tx_data while busy have no effect on the transfer in progress.

Test Plan:
1. Mode 0 loopback (MOSI tied to MISO), cs_sel=0, tx_data=0xA5, start at cycle 10:
   - SS_N=3'b110 from cycle 11;
   - 8 rising SCLK edges;
   - done at cycle 83;
   - rx_data=0xA5, err=0.
2. Mode 3, cs_sel=2, slave model returning 0x3C MSB-first:
   - SCLK idles high;
   - SS_N=3'b011 during the transfer;
   - MISO sampled on rising edges;
   - rx_data=0x3C;
   - the slave model receives the tx_data value 0x81.
3. MSB_FIRST=0, DATA_WIDTH=16, HALF_PERIOD=2, loopback with tx_data=0x1234:
   - first MOSI bit is 0;
   - rx_data=0x1234;
   - done 69 cycles after start.
4. cs_sel=3 with NUM_CS=3:
   - done=1 and err=1 in the next cycle;
   - SS_N stays 3'b111;
   - no SCLK edges;
   - rx_data unchanged.
5. Start pulses at cycles +5 and +40 during a busy transfer, plus a start in the done cycle:
   - all are ignored;
   - exactly one done pulse;
   - a start one cycle after done is accepted.
6. Assert I_RESETN=0 during SHIFT:
   - SS_N=3'b111, SCLK=0, busy=0 and done=0 immediately;
   - after release, a fresh 0x5A loopback completes correctly.
